hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
// - Central stall/flush sequencer for the 5-stage pipeline registers (i2d, d2e, e2m, m2w) and the PC register.
// - Resolves D-cache miss, branch mispredict, load-use and I-cache miss hazards into per-register stall/flush.
// - Holds a pending mispredict across D-cache stalls and extends the I-side flush while fetch is redirected.
// - Keeps saturating perf counters for stall and flush cycles.
// PARAMETERS
// - REDIRECT_CYCLES  1   cycles i2d flush is held after a mispredict is applied (sync I-cache latency); valid range 1..7
// - CNT_W            32  width of each perf counter
// PORTS
// - clk                input   1      clock
// - rst                input   1      synchronous reset, active-high
// - ic_miss            input   1      I-cache output invalid this cycle
// - dc_miss            input   1      D-cache miss outstanding in MEM; level, held until data returns
// - br_mispredict      input   1      one-cycle pulse from EX: resolved branch disagrees with prediction
// - ds_uses_rs/rt      input   1      DEC instruction reads rs/rt
// - ds_rs_addr/rt_addr input   5      DEC source register numbers
// - ex_is_load         input   1      EX holds a valid load (mem_action READ)
// - ex_rw_addr         input   5      EX destination register
// - pc_stall           output  1      hold PC
// - i2d_stall/flush    output  1      hazard control for i2d
// - d2e_stall/flush    output  1      hazard control for d2e
// - e2m_stall/flush    output  1      hazard control for e2m
// - m2w_stall/flush    output  1      hazard control for m2w
// - redirect_active    output  1      high in REDIRECT state or when a mispredict is applied this cycle
// - mispredict_pending output  1      a mispredict is latched, waiting for dc_miss to clear
// - stall_cycles       output  CNT_W  cycles with pc_stall=1; saturates at all-ones
// - flush_events       output  CNT_W  cycles with any *_flush=1; saturates at all-ones
// BEHAVIOUR
// - Interface contract: a pipeline register's stall dominates its flush. A flush takes effect only when that register's stall=0.
// - Stall/flush outputs are combinational from the inputs plus registered state (zero latency). State and counters update on posedge clk.
// - Reset (rst=1 on a clock edge): state<=RUN, pending<=0, redirect count<=0, counters<=0.
// - While rst=1, all stall/flush outputs are 0 and redirect_active=0.
// - Load-use hazard: luh = ex_is_load && ex_rw_addr!=0 && ((ds_uses_rs && ds_rs_addr==ex_rw_addr) || (ds_uses_rt && ds_rt_addr==ex_rw_addr)).
// - A mispredict is applied this cycle (apply) when (br_mispredict || pending) && !dc_miss.
// - Per-cycle priority, first match wins:
//   1. dc_miss: pc, i2d, d2e and e2m stall; m2w flush (bubble into WB). If br_mispredict=1, set pending<=1.
//   2. apply: i2d and d2e flush, no stalls. pending<=0; state<=REDIRECT; cnt<=REDIRECT_CYCLES.
//   3. state==REDIRECT: i2d flush; cnt decrements; return to RUN when cnt==1.
//      luh is impossible here because d2e was flushed. ic_miss also stalls pc.
//   4. luh: pc and i2d stall; d2e flush (bubble into EX).
//   5. ic_miss: pc stall; i2d flush.
//   6. otherwise: all outputs 0.
// - States: RUN, REDIRECT. MEM_WAIT is not a separate state; dc_miss is level-sensitive from any state.
// - A dc_miss during REDIRECT freezes cnt. The REDIRECT flush resumes after the miss clears.
// - A br_mispredict during REDIRECT re-applies: cnt reloads to REDIRECT_CYCLES.
// - Counters increment by 1 per qualifying cycle and saturate (no wrap).
// STRUCTURE
// - Shared package: typedef enum logic {HS_RUN, HS_REDIRECT} hs_state_t; localparam REG_ZERO=5'd0.
// - One sub-module, sat_counter #(W) (en, clr -> q), instantiated twice for the perf counters.
// - The priority encoder lives in a single always_comb.
// TESTING
// - Load-use: ex_is_load=1, ex_rw_addr=5'd8, ds_rs_addr=5'd8, ds_uses_rs=1
//   -> pc_stall=i2d_stall=d2e_flush=1, others 0. Same case with ex_rw_addr=0 -> all 0.
// - D-cache miss: dc_miss high 4 cycles -> pc/i2d/d2e/e2m_stall=1 and m2w_flush=1 for exactly 4 cycles; stall_cycles=4.
// - Mispredict during miss: br_mispredict pulses in cycle 2 of a 3-cycle dc_miss
//   -> mispredict_pending=1 in cycles 3-4; cycle 4 (dc_miss=0): i2d_flush=d2e_flush=1, pending clears.
//   With REDIRECT_CYCLES=2, i2d_flush stays 1 for 2 more cycles.
// - Priority: dc_miss, br_mispredict, luh and ic_miss all high together
//   -> dc_miss pattern only, pending set; i2d/d2e flush occurs once dc_miss drops.
// - I-cache miss: ic_miss=1 alone -> pc_stall=1, i2d_flush=1, i2d_stall=0, downstream all 0.
// - Reset mid-REDIRECT: assert rst -> next cycle state RUN, pending=0, counters=0, all outputs 0 with quiet inputs.
// - Saturation: CNT_W=3 with pc_stall held 10 cycles -> stall_cycles sticks at 7.

Source files
------------

// File: rtl/hazard_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// hazard_sequencer_pkg
// Shared types and constants for the pipeline hazard sequencer.
//   hs_state_t : sequencer state (normal run / fetch redirect in progress)
//   REG_ZERO   : architectural zero register number (never a real hazard)
//   load_use() : load-use hazard detect between EX load and DEC sources
// ----------------------------------------------------------------------------
package hazard_sequencer_pkg;

  typedef enum logic {
    HS_RUN,
    HS_REDIRECT
  } hs_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load into r0 is architecturally discarded, so it can never feed DEC.
  function automatic logic load_use(
    input logic       ex_is_load,
    input logic [4:0] ex_rw_addr,
    input logic       ds_uses_rs,
    input logic [4:0] ds_rs_addr,
    input logic       ds_uses_rt,
    input logic [4:0] ds_rt_addr
  );
    return ex_is_load && (ex_rw_addr != REG_ZERO) &&
           ((ds_uses_rs && (ds_rs_addr == ex_rw_addr)) ||
            (ds_uses_rt && (ds_rt_addr == ex_rw_addr)));
  endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the sequencer performance counters.
//   clk : clock
//   en  : count this cycle (ignored once q is all-ones)
//   clr : synchronous clear, dominates en
//   q   : current count
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// ----------------------------------------------------------------------------
// hazard_sequencer
// Central stall/flush sequencer for the i2d/d2e/e2m/m2w pipeline registers and
// the PC. Resolves D-cache miss, branch mispredict, load-use and I-cache miss
// into per-register stall/flush, holds a mispredict across D-cache stalls and
// keeps the I-side flushed while fetch is redirected.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   ic_miss, dc_miss           cache status (dc_miss is a level)
//   br_mispredict              one-cycle pulse from EX
//   ds_uses_rs/rt, ds_rs/rt_addr   DEC source operands
//   ex_is_load, ex_rw_addr     EX load destination
//   pc_stall, *_stall, *_flush hazard control (stall dominates flush downstream)
//   redirect_active            REDIRECT state or mispredict applied this cycle
//   mispredict_pending         mispredict latched behind a D-cache miss
//   stall_cycles, flush_events saturating perf counters
//
// state        | meaning
// -------------+-------------------------------------------------------------
// HS_RUN       | normal operation, no fetch redirect outstanding
// HS_REDIRECT  | i2d held flushed while the redirected fetch returns
// ----------------------------------------------------------------------------
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ic_miss,
  input  logic             dc_miss,
  input  logic             br_mispredict,
  input  logic             ds_uses_rs,
  input  logic             ds_uses_rt,
  input  logic [4:0]       ds_rs_addr,
  input  logic [4:0]       ds_rt_addr,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rw_addr,
  output logic             pc_stall,
  output logic             i2d_stall,
  output logic             i2d_flush,
  output logic             d2e_stall,
  output logic             d2e_flush,
  output logic             e2m_stall,
  output logic             e2m_flush,
  output logic             m2w_stall,
  output logic             m2w_flush,
  output logic             redirect_active,
  output logic             mispredict_pending,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [2:0] RELOAD = 3'(REDIRECT_CYCLES);

  hs_state_t  state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       pending, pending_nxt;
  logic       luh;
  logic       apply;

  assign luh   = load_use(ex_is_load, ex_rw_addr, ds_uses_rs, ds_rs_addr,
                          ds_uses_rt, ds_rt_addr);
  assign apply = (br_mispredict || pending) && !dc_miss;

  // Priority encoder: first matching hazard owns the cycle.
  always_comb begin
    pc_stall        = 1'b0;
    i2d_stall       = 1'b0;
    i2d_flush       = 1'b0;
    d2e_stall       = 1'b0;
    d2e_flush       = 1'b0;
    e2m_stall       = 1'b0;
    e2m_flush       = 1'b0;
    m2w_stall       = 1'b0;
    m2w_flush       = 1'b0;
    redirect_active = 1'b0;
    state_nxt       = state;
    cnt_nxt         = cnt;
    pending_nxt     = pending;

    if (!rst) begin
      redirect_active = (state == HS_REDIRECT) || apply;

      if (dc_miss) begin
        // Freeze everything up to MEM; WB gets a bubble. REDIRECT count is
        // frozen too, so the I-side flush resumes once the miss clears.
        pc_stall  = 1'b1;
        i2d_stall = 1'b1;
        d2e_stall = 1'b1;
        e2m_stall = 1'b1;
        m2w_flush = 1'b1;
        if (br_mispredict) begin
          pending_nxt = 1'b1;
        end
      end else if (apply) begin
        i2d_flush   = 1'b1;
        d2e_flush   = 1'b1;
        pending_nxt = 1'b0;
        state_nxt   = HS_REDIRECT;
        cnt_nxt     = RELOAD;
      end else if (state == HS_REDIRECT) begin
        // d2e was flushed on apply, so no load-use can be pending here.
        i2d_flush = 1'b1;
        pc_stall  = ic_miss;
        cnt_nxt   = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_nxt = HS_RUN;
        end
      end else if (luh) begin
        pc_stall  = 1'b1;
        i2d_stall = 1'b1;
        d2e_flush = 1'b1;
      end else if (ic_miss) begin
        pc_stall  = 1'b1;
        i2d_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HS_RUN;
      cnt     <= 3'd0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
    end
  end

  assign mispredict_pending = pending;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .en  (pc_stall),
    .clr (rst),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .en  (i2d_flush || d2e_flush || e2m_flush || m2w_flush),
    .clr (rst),
    .q   (flush_events)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// ----------------------------------------------------------------------------
// tb_hazard_sequencer
// Directed bench for hazard_sequencer. Main instance uses REDIRECT_CYCLES=2;
// a second instance with CNT_W=3 shares the stimulus for counter saturation.
// Expected control vectors are pushed to a scoreboard when inputs are driven
// and popped/compared at the following negedge.
// ----------------------------------------------------------------------------
module tb_hazard_sequencer;

  // ctl bit order: pc, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s,
  //                m2w_f, redirect_active, mispredict_pending
  localparam logic [10:0] C_PC   = 11'b100_0000_0000;
  localparam logic [10:0] C_I2DS = 11'b010_0000_0000;
  localparam logic [10:0] C_I2DF = 11'b001_0000_0000;
  localparam logic [10:0] C_D2ES = 11'b000_1000_0000;
  localparam logic [10:0] C_D2EF = 11'b000_0100_0000;
  localparam logic [10:0] C_E2MS = 11'b000_0010_0000;
  localparam logic [10:0] C_M2WF = 11'b000_0000_0100;
  localparam logic [10:0] C_RA   = 11'b000_0000_0010;
  localparam logic [10:0] C_PEND = 11'b000_0000_0001;

  localparam logic [10:0] E_NONE  = 11'b0;
  localparam logic [10:0] E_DC    = C_PC | C_I2DS | C_D2ES | C_E2MS | C_M2WF;
  localparam logic [10:0] E_APPLY = C_I2DF | C_D2EF | C_RA;
  localparam logic [10:0] E_REDIR = C_I2DF | C_RA;
  localparam logic [10:0] E_LUH   = C_PC | C_I2DS | C_D2EF;
  localparam logic [10:0] E_IC    = C_PC | C_I2DF;

  logic clk = 1'b0;
  logic rst;
  logic ic_miss, dc_miss, br_mispredict;
  logic ds_uses_rs, ds_uses_rt;
  logic [4:0] ds_rs_addr, ds_rt_addr, ex_rw_addr;
  logic ex_is_load;

  logic pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush;
  logic e2m_stall, e2m_flush, m2w_stall, m2w_flush;
  logic redirect_active, mispredict_pending;
  logic [31:0] stall_cycles, flush_events;

  logic s_pc_stall, s_i2d_stall, s_i2d_flush, s_d2e_stall, s_d2e_flush;
  logic s_e2m_stall, s_e2m_flush, s_m2w_stall, s_m2w_flush;
  logic s_redirect_active, s_mispredict_pending;
  logic [2:0] s_stall_cycles, s_flush_events;

  logic [10:0] ctl;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  hazard_sequencer #(.REDIRECT_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ic_miss(ic_miss), .dc_miss(dc_miss),
    .br_mispredict(br_mispredict), .ds_uses_rs(ds_uses_rs),
    .ds_uses_rt(ds_uses_rt), .ds_rs_addr(ds_rs_addr), .ds_rt_addr(ds_rt_addr),
    .ex_is_load(ex_is_load), .ex_rw_addr(ex_rw_addr),
    .pc_stall(pc_stall), .i2d_stall(i2d_stall), .i2d_flush(i2d_flush),
    .d2e_stall(d2e_stall), .d2e_flush(d2e_flush), .e2m_stall(e2m_stall),
    .e2m_flush(e2m_flush), .m2w_stall(m2w_stall), .m2w_flush(m2w_flush),
    .redirect_active(redirect_active), .mispredict_pending(mispredict_pending),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_sequencer #(.REDIRECT_CYCLES(1), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .ic_miss(ic_miss), .dc_miss(dc_miss),
    .br_mispredict(br_mispredict), .ds_uses_rs(ds_uses_rs),
    .ds_uses_rt(ds_uses_rt), .ds_rs_addr(ds_rs_addr), .ds_rt_addr(ds_rt_addr),
    .ex_is_load(ex_is_load), .ex_rw_addr(ex_rw_addr),
    .pc_stall(s_pc_stall), .i2d_stall(s_i2d_stall), .i2d_flush(s_i2d_flush),
    .d2e_stall(s_d2e_stall), .d2e_flush(s_d2e_flush), .e2m_stall(s_e2m_stall),
    .e2m_flush(s_e2m_flush), .m2w_stall(s_m2w_stall), .m2w_flush(s_m2w_flush),
    .redirect_active(s_redirect_active),
    .mispredict_pending(s_mispredict_pending),
    .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
  );

  assign ctl = {pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
                e2m_stall, e2m_flush, m2w_stall, m2w_flush,
                redirect_active, mispredict_pending};

  task automatic drive(input logic dc, input logic ic, input logic br,
                       input logic ld, input logic [4:0] rw,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt);
    dc_miss       = dc;
    ic_miss       = ic;
    br_mispredict = br;
    ex_is_load    = ld;
    ex_rw_addr    = rw;
    ds_rs_addr    = rs;
    ds_uses_rs    = urs;
    ds_rt_addr    = rt;
    ds_uses_rt    = urt;
  endtask

  task automatic quiet();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Push expectation, compare at negedge, then advance past the next posedge.
  task automatic step(input string tag, input logic [10:0] exp);
    logic [10:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (ctl === e) else begin
      errors++;
      $error("FAIL %s: ctl observed %b expected %b", t, ctl, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    @(posedge clk);
    #1;
    step("rst_hold", E_NONE);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    quiet();
    do_reset();
    check_cnt("rst_stall_cnt", stall_cycles, 32'd0);
    check_cnt("rst_flush_cnt", flush_events, 32'd0);

    step("idle", E_NONE);

    // Load-use on rs, on rt, with r0 destination, and non-load
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    step("luh_rs", E_LUH);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    step("luh_r0", E_NONE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd3, 1'b1, 5'd8, 1'b1);
    step("luh_rt", E_LUH);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1);
    step("luh_noload", E_NONE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 1'b0, 5'd8, 1'b0);
    step("luh_unused", E_NONE);

    // I-cache miss alone
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("ic_miss", E_IC);
    quiet();
    step("ic_done", E_NONE);

    // D-cache miss for 4 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      step("dc_miss", E_DC);
    end
    check_cnt("dc_stall_cnt", stall_cycles, 32'd4);
    check_cnt("dc_flush_cnt", flush_events, 32'd4);
    quiet();
    step("dc_done", E_NONE);

    // Mispredict in cycle 2 of a 3-cycle miss
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("mp_c1", E_DC);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("mp_c2", E_DC);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("mp_c3", E_DC | C_PEND);
    quiet();
    step("mp_c4_apply", E_APPLY | C_PEND);
    step("mp_redir1", E_REDIR);
    step("mp_redir2", E_REDIR);
    step("mp_done", E_NONE);

    // Everything at once; then ic_miss during REDIRECT also stalls pc
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    step("prio_all", E_DC);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    step("prio_apply", E_APPLY | C_PEND);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("redir_ic", E_REDIR | C_PC);
    quiet();
    step("redir_last", E_REDIR);
    step("prio_done", E_NONE);

    // dc_miss freezes the REDIRECT count
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("frz_apply", E_APPLY);
    quiet();
    step("frz_redir1", E_REDIR);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("frz_dc1", E_DC | C_RA);
    step("frz_dc2", E_DC | C_RA);
    quiet();
    step("frz_redir2", E_REDIR);
    step("frz_done", E_NONE);

    // Mispredict during REDIRECT reloads the count
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("rl_apply1", E_APPLY);
    quiet();
    step("rl_redir", E_REDIR);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("rl_apply2", E_APPLY);
    quiet();
    step("rl_redir_a", E_REDIR);
    step("rl_redir_b", E_REDIR);
    step("rl_done", E_NONE);

    // Reset in the middle of REDIRECT, with busy inputs while rst is high
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("rr_apply", E_APPLY);
    quiet();
    step("rr_redir", E_REDIR);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    step("rr_rst_gate", E_NONE);
    rst = 1'b0;
    quiet();
    step("rr_after", E_NONE);
    check_cnt("rr_stall_cnt", stall_cycles, 32'd0);
    check_cnt("rr_flush_cnt", flush_events, 32'd0);

    // Counter saturation: 10 stall cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      step("sat_dc", E_DC);
    end
    quiet();
    check_cnt("sat_stall_w3", 32'(s_stall_cycles), 32'd7);
    check_cnt("sat_flush_w3", 32'(s_flush_events), 32'd7);
    check_cnt("sat_stall_w32", stall_cycles, 32'd10);
    step("sat_done", E_NONE);
    check_cnt("sat_hold_w3", 32'(s_stall_cycles), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
